// File: rtl/main_mem_responder_pkg.sv
// rtl/main_mem_responder_pkg.sv - shared state encoding and default geometry for main memory and cache
package main_mem_responder_pkg;

  typedef enum logic [1:0] {MEM_IDLE, MEM_WAIT, MEM_BURST, MEM_WACK} mem_state_e;

  localparam int MEM_LATENCY     = 4;
  localparam int MEM_BLOCK_WORDS = 4;
  localparam int MEM_DATA_W      = 32;

endpackage

// File: rtl/main_mem_responder_if.sv
// rtl/main_mem_responder_if.sv - cache controller to main memory request/response bundle
interface main_mem_responder_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int BEAT_W = 2
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_busy;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic [BEAT_W-1:0] mem_beat;
  logic              mem_done;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_busy, mem_rvalid, mem_rdata, mem_beat, mem_done
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_busy, mem_rvalid, mem_rdata, mem_beat, mem_done
  );
endinterface

// File: rtl/main_mem_responder_array.sv
// rtl/main_mem_responder_array.sv - single-port word RAM with registered, clearable read port
module main_mem_array #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 1024,
  parameter     INIT_FILE = ""
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic                     we_i,
  input  logic                     re_i,
  input  logic [DATA_W-1:0]        wdata_i,
  output logic [DATA_W-1:0]        rdata_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Array contents survive reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Read data is zero whenever no beat is scheduled, so the output needs no gating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= re_i ? mem_q[addr_i] : '0;
    end
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/main_mem_responder.sv
// rtl/main_mem_responder.sv - main memory responder: block read bursts and single-word writes after fixed latency
module main_mem_responder
  import main_mem_responder_pkg::*;
#(
  parameter int DATA_W      = MEM_DATA_W,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 1024,
  parameter int BLOCK_WORDS = MEM_BLOCK_WORDS,
  parameter int LATENCY     = MEM_LATENCY,
  parameter     INIT_FILE   = ""
) (
  input logic                 clk,
  input logic                 RST,
  main_mem_responder_if.slave bus
);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int BEAT_W = $clog2(BLOCK_WORDS);
  localparam int CNT_W  = $clog2(LATENCY + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BLOCK_WORDS - 1);

  mem_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              we_q, we_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              busy_q, busy_d;
  logic              rvalid_q, rvalid_d;
  logic              done_q, done_d;

  logic              ram_re, ram_we;
  logic [BEAT_W-1:0] rd_beat;
  logic [IDX_W-1:0]  ram_addr;
  logic [DATA_W-1:0] ram_rdata;
  logic              addr_unused;

  assign addr_unused = ^{bus.mem_addr[ADDR_W-1:IDX_W+2], bus.mem_addr[1:0]};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    beat_d   = '0;
    we_d     = we_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    busy_d   = 1'b0;
    rvalid_d = 1'b0;
    done_d   = 1'b0;
    ram_re   = 1'b0;
    ram_we   = 1'b0;
    rd_beat  = '0;
    unique case (state_q)
      MEM_IDLE: begin
        if (bus.mem_req) begin
          we_d    = bus.mem_we;
          idx_d   = bus.mem_addr[IDX_W+1:2];
          wdata_d = bus.mem_wdata;
          cnt_d   = CNT_W'(LATENCY - 1);
          busy_d  = 1'b1;
          state_d = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        busy_d = 1'b1;
        if (cnt_q == '0) begin
          if (we_q) begin
            done_d  = 1'b1;
            state_d = MEM_WACK;
          end else begin
            // Issue the read for beat 0 now so it lands in the data register with rvalid.
            rvalid_d = 1'b1;
            ram_re   = 1'b1;
            state_d  = MEM_BURST;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      MEM_BURST: begin
        if (beat_q != LAST_BEAT) begin
          beat_d   = beat_q + BEAT_W'(1);
          rd_beat  = beat_d;
          busy_d   = 1'b1;
          rvalid_d = 1'b1;
          ram_re   = 1'b1;
          done_d   = (beat_d == LAST_BEAT);
        end else begin
          state_d = MEM_IDLE;
        end
      end
      MEM_WACK: begin
        ram_we  = 1'b1;
        state_d = MEM_IDLE;
      end
      default: state_d = MEM_IDLE;
    endcase
  end

  assign ram_addr = ram_we ? idx_q : {idx_q[IDX_W-1:BEAT_W], rd_beat};

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q  <= MEM_IDLE;
      cnt_q    <= '0;
      beat_q   <= '0;
      we_q     <= 1'b0;
      idx_q    <= '0;
      wdata_q  <= '0;
      busy_q   <= 1'b0;
      rvalid_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      beat_q   <= beat_d;
      we_q     <= we_d;
      idx_q    <= idx_d;
      wdata_q  <= wdata_d;
      busy_q   <= busy_d;
      rvalid_q <= rvalid_d;
      done_q   <= done_d;
    end
  end

  main_mem_array #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .INIT_FILE(INIT_FILE)
  ) u_array (
    .clk    (clk),
    .rst    (RST),
    .addr_i (ram_addr),
    .we_i   (ram_we),
    .re_i   (ram_re),
    .wdata_i(wdata_q),
    .rdata_o(ram_rdata)
  );

  assign bus.mem_busy   = busy_q;
  assign bus.mem_rvalid = rvalid_q;
  assign bus.mem_rdata  = ram_rdata;
  assign bus.mem_beat   = beat_q;
  assign bus.mem_done   = done_q;
endmodule

// File: tb/tb_main_mem_responder.sv
// tb/tb_main_mem_responder.sv - directed self-checking bench for main_mem_responder
module tb_main_mem_responder;
  localparam int LAT = 4;
  localparam int BW  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  main_mem_responder_if #(.DATA_W(32), .ADDR_W(32), .BEAT_W(2)) bus ();

  main_mem_responder #(
    .DATA_W(32), .ADDR_W(32), .DEPTH(1024), .BLOCK_WORDS(BW), .LATENCY(LAT), .INIT_FILE("")
  ) dut (
    .clk(clk),
    .RST(rst),
    .bus(bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] data);
    bus.mem_we    = we;
    bus.mem_addr  = addr;
    bus.mem_wdata = data;
    bus.mem_req   = 1'b1;
    step();
    bus.mem_req   = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
    issue(1'b1, addr, data);
    repeat (LAT + 1) step();
  endtask

  // Captures one read burst; returns in the first IDLE cycle after it.
  task automatic run_read(input logic [31:0] addr, output logic [3:0][31:0] beats,
                          output int first_cyc, output int done_cyc, output int nvalid,
                          output logic busy_end);
    beats = '0; first_cyc = -1; done_cyc = -1; nvalid = 0;
    issue(1'b0, addr, 32'h0);
    for (int c = 0; c < LAT + BW; c++) begin
      if (bus.mem_rvalid) begin
        if (first_cyc < 0) first_cyc = c;
        beats[bus.mem_beat] = bus.mem_rdata;
        nvalid++;
      end
      if (bus.mem_done) done_cyc = c;
      step();
    end
    busy_end = bus.mem_busy;
  endtask

  task automatic test_reset();
    repeat (2) step();
    tests_run++;
    if ({bus.mem_busy, bus.mem_rvalid, bus.mem_done} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got busy/rvalid/done %b expected 000", {bus.mem_busy, bus.mem_rvalid, bus.mem_done});
    end
    tests_run++;
    if (bus.mem_rdata !== 32'h0 || bus.mem_beat !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_data: got rdata %h beat %0d expected 0 0", bus.mem_rdata, bus.mem_beat);
    end
    rst = 1'b0;
    step();
    tests_run++;
    if (bus.mem_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_idle: got busy %b expected 0", bus.mem_busy);
    end
  endtask

  task automatic preload();
    for (int i = 0; i < 16; i++) do_write(32'(i * 4), 32'(i * 'h11));
  endtask

  task automatic test_read_block();
    logic [3:0][31:0] b; int fc, dc, nv; logic be;
    logic [3:0][31:0] exp_b;
    exp_b = {32'hBB, 32'hAA, 32'h99, 32'h88};
    run_read(32'h0000_0028, b, fc, dc, nv, be);
    for (int k = 0; k < BW; k++) begin
      tests_run++;
      if (b[k] !== exp_b[k]) begin
        tests_failed++;
        $display("FAIL read_beat%0d: got %h expected %h", k, b[k], exp_b[k]);
      end
    end
    tests_run++;
    if (fc !== LAT || dc !== LAT + BW - 1 || nv !== BW) begin
      tests_failed++;
      $display("FAIL read_timing: got first %0d done %0d beats %0d expected 4 7 4", fc, dc, nv);
    end
    tests_run++;
    if (be !== 1'b0 || bus.mem_rvalid !== 1'b0 || bus.mem_rdata !== 32'h0 || bus.mem_beat !== 2'd0) begin
      tests_failed++;
      $display("FAIL read_after: got busy %b rvalid %b rdata %h beat %0d expected 0 0 0 0",
               be, bus.mem_rvalid, bus.mem_rdata, bus.mem_beat);
    end
  endtask

  task automatic test_write_then_read();
    logic [3:0][31:0] b; int fc, dc, nv; logic be;
    logic [3:0][31:0] exp_b;
    exp_b = {32'h77, 32'h66, 32'h55, 32'hDEAD_BEEF};
    issue(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    for (int c = 0; c <= LAT; c++) begin
      tests_run++;
      if (bus.mem_busy !== 1'b1 || bus.mem_done !== (c == LAT)) begin
        tests_failed++;
        $display("FAIL write_cycle%0d: got busy %b done %b expected 1 %b", c, bus.mem_busy, bus.mem_done, c == LAT);
      end
      step();
    end
    tests_run++;
    if (bus.mem_busy !== 1'b0 || bus.mem_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL write_end: got busy %b done %b expected 0 0", bus.mem_busy, bus.mem_done);
    end
    run_read(32'h0000_0010, b, fc, dc, nv, be);
    for (int k = 0; k < BW; k++) begin
      tests_run++;
      if (b[k] !== exp_b[k]) begin
        tests_failed++;
        $display("FAIL raw_beat%0d: got %h expected %h", k, b[k], exp_b[k]);
      end
    end
    tests_run++;
    if (fc !== LAT) begin
      tests_failed++;
      $display("FAIL raw_latency: got %0d expected 4", fc);
    end
  endtask

  task automatic test_req_held();
    bus.mem_we = 1'b0; bus.mem_addr = 32'h0000_0028; bus.mem_wdata = 32'h0; bus.mem_req = 1'b1;
    step();
    for (int c = 0; c < LAT + BW; c++) begin
      if (c >= LAT) begin
        tests_run++;
        if (bus.mem_rvalid !== 1'b1 || bus.mem_beat !== 2'(c - LAT) || bus.mem_rdata !== 32'h88 + 32'h11 * 32'(c - LAT)) begin
          tests_failed++;
          $display("FAIL held_beat%0d: got rvalid %b beat %0d rdata %h expected 1 %0d %h", c - LAT,
                   bus.mem_rvalid, bus.mem_beat, bus.mem_rdata, c - LAT, 32'h88 + 32'h11 * 32'(c - LAT));
        end
      end
      if (c < 6) begin
        bus.mem_addr  = (c % 2 == 0) ? 32'h0000_03C0 : 32'h0000_000C;
        bus.mem_we    = (c % 2 == 1);
        bus.mem_wdata = 32'hFFFF_FFFF;
      end else begin
        bus.mem_addr = 32'h0000_0018;
        bus.mem_we   = 1'b0;
      end
      step();
    end
    tests_run++;
    if (bus.mem_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL held_idle: got busy %b expected 0", bus.mem_busy);
    end
    step();
    bus.mem_req = 1'b0;
    tests_run++;
    if (bus.mem_busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL held_accept: got busy %b expected 1", bus.mem_busy);
    end
    repeat (LAT) step();
    tests_run++;
    if (bus.mem_rvalid !== 1'b1 || bus.mem_rdata !== 32'hDEAD_BEEF) begin
      tests_failed++;
      $display("FAIL held_second: got rvalid %b rdata %h expected 1 deadbeef", bus.mem_rvalid, bus.mem_rdata);
    end
    repeat (BW) step();
  endtask

  task automatic test_wrap();
    logic [3:0][31:0] b; int fc, dc, nv; logic be;
    logic [3:0][31:0] exp_b;
    exp_b = {32'h33, 32'h22, 32'h11, 32'h00};
    run_read(32'h0000_1004, b, fc, dc, nv, be);
    for (int k = 0; k < BW; k++) begin
      tests_run++;
      if (b[k] !== exp_b[k]) begin
        tests_failed++;
        $display("FAIL wrap_beat%0d: got %h expected %h", k, b[k], exp_b[k]);
      end
    end
  endtask

  task automatic test_reset_mid_read();
    logic [3:0][31:0] b; int fc, dc, nv; logic be;
    logic seen;
    issue(1'b0, 32'h0000_0028, 32'h0);
    repeat (5) step();
    tests_run++;
    if (bus.mem_rvalid !== 1'b1 || bus.mem_rdata !== 32'h99) begin
      tests_failed++;
      $display("FAIL rstrd_pre: got rvalid %b rdata %h expected 1 99", bus.mem_rvalid, bus.mem_rdata);
    end
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if ({bus.mem_busy, bus.mem_rvalid, bus.mem_done} !== 3'b000 || bus.mem_rdata !== 32'h0 || bus.mem_beat !== 2'd0) begin
      tests_failed++;
      $display("FAIL rstrd_async: got busy %b rvalid %b done %b rdata %h beat %0d expected all 0",
               bus.mem_busy, bus.mem_rvalid, bus.mem_done, bus.mem_rdata, bus.mem_beat);
    end
    step();
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (bus.mem_done || bus.mem_busy || bus.mem_rvalid) seen = 1'b1;
      step();
    end
    tests_run++;
    if (seen !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstrd_quiet: got activity %b expected 0", seen);
    end
    run_read(32'h0000_0028, b, fc, dc, nv, be);
    tests_run++;
    if (b !== {32'hBB, 32'hAA, 32'h99, 32'h88} || fc !== LAT || dc !== LAT + BW - 1) begin
      tests_failed++;
      $display("FAIL rstrd_reread: got %h first %0d done %0d expected bb_aa_99_88 4 7", b, fc, dc);
    end
  endtask

  task automatic test_reset_wack();
    logic [3:0][31:0] b; int fc, dc, nv; logic be;
    issue(1'b1, 32'h0000_000C, 32'h0000_1234);
    repeat (LAT) step();
    tests_run++;
    if (bus.mem_done !== 1'b1) begin
      tests_failed++;
      $display("FAIL rstwr_wack: got done %b expected 1", bus.mem_done);
    end
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (bus.mem_done !== 1'b0 || bus.mem_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstwr_async: got done %b busy %b expected 0 0", bus.mem_done, bus.mem_busy);
    end
    step();
    rst = 1'b0;
    step();
    run_read(32'h0000_000C, b, fc, dc, nv, be);
    tests_run++;
    if (b[3] !== 32'h33 || b[0] !== 32'h00) begin
      tests_failed++;
      $display("FAIL rstwr_dropped: got word3 %h word0 %h expected 33 00", b[3], b[0]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = 32'h0;
    bus.mem_wdata = 32'h0;
    test_reset();
    preload();
    test_read_block();
    test_write_then_read();
    test_req_held();
    test_wrap();
    test_reset_mid_read();
    test_reset_wack();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
